// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory / load-store unit.
//   func3_e : RISC-V load/store funct3 encodings understood by the LSU
//   state_e : access FSM states (IDLE -> WAIT -> RESP -> IDLE)
package dmem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } func3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   func3_i      funct3 of the access
//   we_i         1 = store (makes BU/HU illegal)
//   addr_lo_i    byte offset within the word
//   wdata_i      raw store data from the core
//   rword_i      32-bit word read from the array
//   be_o         byte-lane write enables
//   wdata_o      store data replicated across lanes
//   rdata_o      selected and sign/zero-extended load data
//   misaligned_o H/HU not half-aligned, or W not word-aligned
//   illegal_o    funct3 not a legal load/store encoding for this direction
module lsu_align
  import dmem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic        we_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rword_i[7:0];
      2'd1:    byte_sel = rword_i[15:8];
      2'd2:    byte_sel = rword_i[23:16];
      default: byte_sel = rword_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = wdata_i;
    rdata_o      = 32'h0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (func3_e'(func3_i))
      F3_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {{16{half_sel[15]}}, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      F3_W: begin
        be_o         = 4'b1111;
        rdata_o      = rword_i;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      // Unsigned variants exist only for loads.
      F3_BU: begin
        rdata_o   = {24'h0, byte_sel};
        illegal_o = we_i;
      end
      F3_HU: begin
        rdata_o      = {16'h0, half_sel};
        misaligned_o = addr_lo_i[0];
        illegal_o    = we_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with a load/store front end and wait states.
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so the core holds
// the request until then. Inputs are sampled only at accept. rsp_valid is a
// one-cycle pulse; rsp_rdata/rsp_fault/rsp_fault_addr are meaningful only with it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               request channel (valid/ready, we, func3, addr, wdata)
//   rsp_*               response channel (valid, rdata, fault, fault_addr)
//   dbg_state           current FSM state
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [ADDR_W-1:0] rsp_fault_addr,
  output state_e            dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(WORD_BYTES * DEPTH_WORDS);
  localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, fault_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q, rsp_fault_q;
  logic [31:0]       rsp_rdata_q;
  logic [ADDR_W-1:0] rsp_fault_addr_q;

  logic [31:0] mem [DEPTH_WORDS];

  // In IDLE the lane logic looks at the live request (fault check and the
  // zero-wait-state write); afterwards it looks at the captured request.
  logic             in_idle;
  logic [2:0]       cur_func3;
  logic             cur_we;
  logic [1:0]       cur_lo;
  logic [31:0]      cur_wdata;
  logic [IDX_W-1:0] cur_idx;
  logic [3:0]       be;
  logic [31:0]      wdata_rep, load_data;
  logic             misaligned, illegal, out_of_range, fault_now;
  logic             accept, mem_we;

  assign in_idle   = (state_q == S_IDLE);
  assign cur_func3 = in_idle ? req_func3 : func3_q;
  assign cur_we    = in_idle ? req_we : we_q;
  assign cur_lo    = in_idle ? req_addr[1:0] : addr_q[1:0];
  assign cur_wdata = in_idle ? req_wdata : wdata_q;
  assign cur_idx   = in_idle ? req_addr[IDX_W+1:2] : addr_q[IDX_W+1:2];

  lsu_align u_align (
    .func3_i      (cur_func3),
    .we_i         (cur_we),
    .addr_lo_i    (cur_lo),
    .wdata_i      (cur_wdata),
    .rword_i      (mem[cur_idx]),
    .be_o         (be),
    .wdata_o      (wdata_rep),
    .rdata_o      (load_data),
    .misaligned_o (misaligned),
    .illegal_o    (illegal)
  );

  assign out_of_range = ({1'b0, req_addr} >= BYTE_LIMIT);
  assign fault_now    = misaligned | illegal | out_of_range;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (fault_now || (WAIT_STATES == 0)) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs of the FSM; the store commits on the edge that leaves for RESP.
  always_comb begin
    req_ready = in_idle;
    accept    = in_idle & req_valid;
    mem_we    = ~rst & ((accept & ~fault_now & req_we & (WAIT_STATES == 0)) |
                        ((state_q == S_WAIT) & (cnt_q == LAST_CNT) & we_q));
  end

  // Request capture
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      func3_q <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      func3_q <= req_func3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      fault_q <= fault_now;
    end
  end

  // Response register: everything but the pulse cycle reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= 32'h0;
      rsp_fault_q      <= 1'b0;
      rsp_fault_addr_q <= '0;
    end else begin
      rsp_valid_q      <= (state_q == S_RESP);
      rsp_rdata_q      <= ((state_q == S_RESP) && !we_q && !fault_q) ? load_data : 32'h0;
      rsp_fault_q      <= (state_q == S_RESP) && fault_q;
      rsp_fault_addr_q <= ((state_q == S_RESP) && fault_q) ? addr_q : '0;
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be[b]) mem[cur_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_fault      = rsp_fault_q;
  assign rsp_fault_addr = rsp_fault_addr_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: two instances, WAIT_STATES=0 (index 0) and
// WAIT_STATES=3 (index 1), exercised one after the other with the same scenarios.
module tb_data_mem_lsu;
  import dmem_pkg::*;

  localparam int DW = 1024;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_func3 [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_fault [2];
  logic [31:0] rsp_fault_addr [2];
  state_e      dbg_state [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_lsu #(.DEPTH_WORDS(DW), .WAIT_STATES(0), .ADDR_W(32)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_func3(req_func3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_fault(rsp_fault[0]), .rsp_fault_addr(rsp_fault_addr[0]), .dbg_state(dbg_state[0])
  );

  data_mem_lsu #(.DEPTH_WORDS(DW), .WAIT_STATES(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_func3(req_func3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_fault(rsp_fault[1]), .rsp_fault_addr(rsp_fault_addr[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [64:0] exp_q[$];  // {fault, fault_addr, rdata}

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    req_valid[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst[d] = 1'b0;
  endtask

  task automatic access(input int d, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input bit exp_fault);
    logic [64:0] e;
    bit got, ready_bad;
    int lat, exp_lat;
    exp_q.push_back({exp_fault, (exp_fault ? addr : 32'h0), exp_rdata});
    req_valid[d] = 1'b1; req_we[d] = we; req_func3[d] = f3;
    req_addr[d] = addr; req_wdata[d] = wdata;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready[d];
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout dut%0d addr=%h: req_ready never high", d, addr);
      req_valid[d] = 1'b0;
      void'(exp_q.pop_front());
      @(posedge clk); #1;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the DUT must not look at them again.
    req_valid[d] = 1'b0; req_we[d] = $urandom_range(0, 1);
    req_func3[d] = 3'($urandom_range(0, 7)); req_addr[d] = $urandom; req_wdata[d] = $urandom;
    exp_lat = exp_fault ? 2 : 2 + ws_of(d);
    got = 1'b0; ready_bad = 1'b0; lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[d]) got = 1'b1;
      else if (req_ready[d]) ready_bad = 1'b1;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL rsp_timeout dut%0d addr=%h: no rsp_valid within 20 cycles", d, addr);
      @(posedge clk); #1;
      return;
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL latency dut%0d addr=%h: got %0d expected %0d", d, addr, lat, exp_lat);
    end
    n_checks++;
    if (ready_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_busy dut%0d addr=%h: req_ready high before response", d, addr);
    end
    n_checks++;
    if (rsp_rdata[d] !== e[31:0]) begin
      n_fail++;
      $display("FAIL rdata dut%0d addr=%h: got %h expected %h", d, addr, rsp_rdata[d], e[31:0]);
    end
    n_checks++;
    if (rsp_fault[d] !== e[64]) begin
      n_fail++;
      $display("FAIL fault dut%0d addr=%h: got %b expected %b", d, addr, rsp_fault[d], e[64]);
    end
    if (e[64]) begin
      n_checks++;
      if (rsp_fault_addr[d] !== e[63:32]) begin
        n_fail++;
        $display("FAIL fault_addr dut%0d: got %h expected %h", d, rsp_fault_addr[d], e[63:32]);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid[d], rsp_fault[d], rsp_rdata[d]} !== 34'h0) begin
      n_fail++;
      $display("FAIL rsp_clear dut%0d: valid=%b fault=%b rdata=%h expected all 0",
               d, rsp_valid[d], rsp_fault[d], rsp_rdata[d]);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset(input int d);
    @(negedge clk);
    n_checks++;
    if ({req_ready[d], rsp_valid[d], rsp_fault[d]} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags dut%0d: ready/valid/fault=%b%b%b expected 100",
               d, req_ready[d], rsp_valid[d], rsp_fault[d]);
    end
    n_checks++;
    if (rsp_rdata[d] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata dut%0d: got %h expected 0", d, rsp_rdata[d]);
    end
    n_checks++;
    if (rsp_fault_addr[d] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_fault_addr dut%0d: got %h expected 0", d, rsp_fault_addr[d]);
    end
    n_checks++;
    if (dbg_state[d] !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_state dut%0d: got %0d expected IDLE", d, dbg_state[d]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sw_lw(input int d);
    access(d, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access(d, 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_byte_lanes(input int d);
    access(d, 1'b1, F3_W,  32'h20, 32'h11223344, 32'h0, 1'b0);
    access(d, 1'b1, F3_B,  32'h21, 32'h123456AA, 32'h0, 1'b0);
    access(d, 1'b0, F3_B,  32'h21, 32'h0, 32'hFFFFFFAA, 1'b0);
    access(d, 1'b0, F3_BU, 32'h21, 32'h0, 32'h000000AA, 1'b0);
    access(d, 1'b0, F3_W,  32'h20, 32'h0, 32'h1122AA44, 1'b0);
  endtask

  task automatic test_half(input int d);
    access(d, 1'b1, F3_W,  32'h30, 32'h76543210, 32'h0, 1'b0);
    access(d, 1'b1, F3_H,  32'h32, 32'hABCD8001, 32'h0, 1'b0);
    access(d, 1'b0, F3_H,  32'h32, 32'h0, 32'hFFFF8001, 1'b0);
    access(d, 1'b0, F3_HU, 32'h32, 32'h0, 32'h00008001, 1'b0);
    access(d, 1'b0, F3_HU, 32'h30, 32'h0, 32'h00003210, 1'b0);
    access(d, 1'b0, F3_W,  32'h30, 32'h0, 32'h80013210, 1'b0);
  endtask

  task automatic test_faults(input int d);
    access(d, 1'b1, F3_W,  32'h0,    32'h0BADF00D, 32'h0, 1'b0);
    access(d, 1'b0, F3_W,  32'h12,   32'h0, 32'h0, 1'b1);
    access(d, 1'b1, F3_H,  32'h31,   32'hFFFFFFFF, 32'h0, 1'b1);
    access(d, 1'b1, F3_W,  4 * DW,   32'hFFFFFFFF, 32'h0, 1'b1);
    access(d, 1'b1, 3'b011, 32'h0,   32'hFFFFFFFF, 32'h0, 1'b1);
    access(d, 1'b1, F3_BU, 32'h30,   32'hFFFFFFFF, 32'h0, 1'b1);
    access(d, 1'b0, 3'b110, 32'h30,  32'h0, 32'h0, 1'b1);
    access(d, 1'b0, F3_W,  32'h30,   32'h0, 32'h80013210, 1'b0);
    access(d, 1'b0, F3_W,  32'h0,    32'h0, 32'h0BADF00D, 1'b0);
  endtask

  task automatic test_back_to_back(input int d);
    logic [31:0] dat [4];
    logic [64:0] e;
    int acc_cyc [4];
    int n_acc, n_rsp;
    n_acc = 0; n_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      dat[i] = $urandom;
      acc_cyc[i] = 0;
    end
    req_valid[d] = 1'b1; req_we[d] = 1'b1; req_func3[d] = F3_W;
    req_addr[d] = 32'h50; req_wdata[d] = dat[0];
    for (int t = 0; t < 100 && (n_acc < 4 || n_rsp < 4); t++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin
        n_rsp++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_rsp dut%0d: response with nothing outstanding", d);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_fault[d], rsp_rdata[d]} !== {e[64], e[31:0]}) begin
            n_fail++;
            $display("FAIL b2b_rsp dut%0d: fault/rdata=%b/%h expected %b/%h",
                     d, rsp_fault[d], rsp_rdata[d], e[64], e[31:0]);
          end
        end
      end
      if (req_valid[d] && req_ready[d]) begin
        @(posedge clk);
        #1;
        acc_cyc[n_acc] = cyc;
        n_acc++;
        exp_q.push_back(65'h0);
        if (n_acc < 4) begin
          req_addr[d] = 32'h50 + 32'(4 * n_acc);
          req_wdata[d] = dat[n_acc];
        end else begin
          req_valid[d] = 1'b0;
        end
      end
    end
    req_valid[d] = 1'b0;
    exp_q.delete();
    n_checks++;
    if (n_acc !== 4 || n_rsp !== 4) begin
      n_fail++;
      $display("FAIL b2b_count dut%0d: accepts=%0d responses=%0d expected 4/4", d, n_acc, n_rsp);
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 2 + ws_of(d)) begin
        n_fail++;
        $display("FAIL b2b_spacing dut%0d gap%0d: got %0d expected %0d",
                 d, i, acc_cyc[i] - acc_cyc[i-1], 2 + ws_of(d));
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      access(d, 1'b0, F3_W, 32'h50 + 32'(4 * i), 32'h0, dat[i], 1'b0);
  endtask

  task automatic test_rst_abort(input int d);
    bit seen;
    bit got;
    access(d, 1'b1, F3_W, 32'h40, 32'h0, 32'h0, 1'b0);
    req_valid[d] = 1'b1; req_we[d] = 1'b1; req_func3[d] = F3_W;
    req_addr[d] = 32'h40; req_wdata[d] = 32'h55;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready[d];
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    rst[d] = 1'b1;
    @(posedge clk);
    #1 rst[d] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state[d] !== S_IDLE || req_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle dut%0d: state=%0d ready=%b expected IDLE/1", d, dbg_state[d], req_ready[d]);
    end
    seen = rsp_valid[d];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid[d]) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rsp dut%0d: rsp_valid seen after abort, expected none", d);
    end
    @(posedge clk); #1;
    // Without wait states the store commits at accept, before rst can land.
    access(d, 1'b0, F3_W, 32'h40, 32'h0, (ws_of(d) == 0) ? 32'h55 : 32'h0, 1'b0);
    // Reset together with a valid request: the request must not be taken.
    req_valid[d] = 1'b1; req_we[d] = 1'b0; req_func3[d] = F3_W; req_addr[d] = 32'h40;
    rst[d] = 1'b1;
    @(posedge clk);
    #1 rst[d] = 1'b0; req_valid[d] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state[d] !== S_IDLE) begin
      n_fail++;
      $display("FAIL rst_vs_accept dut%0d: state=%0d expected IDLE", d, dbg_state[d]);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_func3[d] = 3'd0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
    end
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      test_reset(d);
      test_sw_lw(d);
      test_byte_lanes(d);
      test_half(d);
      test_faults(d);
      test_back_to_back(d);
      test_rst_abort(d);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (%0d checks, %0d failures)", n_checks, n_fail);
    $fatal(1);
  end

endmodule
